// File: rtl/quad_encoder_array.sv
// quad_encoder_array
//   Multi-channel quadrature decoder. Each channel synchronises its A/B/index
//   pins, glitch-filters them, and keeps a wrapping signed position count with
//   index zeroing and a sticky illegal-transition flag. A shared window counter
//   samples a per-channel saturated velocity (counts per window).
//
// Ports
//   CLK             system clock
//   reset           asynchronous active-high reset
//   quadA/quadB     encoder phases, one bit per channel (asynchronous)
//   index           encoder index pulses (asynchronous)
//   zero_on_index   per channel: zero count on filtered index rising edge
//   clear           per channel: level-sensitive synchronous count clear
//   error_clear     clears every sticky error bit
//   count           signed positions, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   velocity        signed counts/window, channel i at [i*VEL_WIDTH +: VEL_WIDTH]
//   velocity_valid  one-cycle strobe when all velocity fields update
//   error           sticky illegal-transition flags

// Per-signal glitch filter: the output follows the input only after the input
// has differed from it for FILTER_CYCLES consecutive cycles.
module qe_filter #(
  parameter int FILTER_CYCLES = 100
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic [FW-1:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == FW'(FILTER_CYCLES - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + FW'(1);
    end
  end
endmodule

// One encoder channel: sync, filter, decode, count, error, velocity sample.
module qe_lane #(
  parameter int COUNT_WIDTH   = 24,
  parameter int FILTER_CYCLES = 100,
  parameter int VEL_WIDTH     = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   a,
  input  logic                   b,
  input  logic                   idx,
  input  logic                   zero_on_index,
  input  logic                   clear,
  input  logic                   error_clear,
  input  logic                   tick,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [VEL_WIDTH-1:0]   velocity,
  output logic                   error
);
  // Extended width wide enough to hold both the raw delta and the VEL range.
  localparam int EW = ((COUNT_WIDTH > VEL_WIDTH) ? COUNT_WIDTH : VEL_WIDTH) + 1;
  localparam logic signed [EW-1:0] VMAX = EW'((1 << (VEL_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] VMIN = ~VMAX;

  // Bit order in all 3-bit vectors: [2]=A, [1]=B, [0]=index.
  logic [2:0] sync1, sync2, filt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b, idx};
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_filt
    qe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .CLK   (CLK),
      .reset (reset),
      .d     (sync2[k]),
      .q     (filt[k])
    );
  end

  logic [1:0] prev_ab, cur_ab;
  logic       prev_idx;
  logic       step_fwd, step_rev, illegal, idx_rise;

  assign cur_ab = filt[2:1];

  // Forward (A leads B): 00 -> 10 -> 11 -> 01 -> 00, reverse is the mirror.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_rev = 1'b1;
      default: ;
    endcase
  end

  assign illegal  = &(prev_ab ^ cur_ab);
  assign idx_rise = filt[0] & ~prev_idx;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prev_ab  <= '0;
      prev_idx <= 1'b0;
      count    <= '0;
      error    <= 1'b0;
    end else begin
      prev_ab  <= cur_ab;
      prev_idx <= filt[0];
      // Clear beats index zeroing, which beats (and discards) a same-cycle step.
      if (clear)
        count <= '0;
      else if (idx_rise && zero_on_index)
        count <= '0;
      else if (step_fwd)
        count <= count + COUNT_WIDTH'(1);
      else if (step_rev)
        count <= count - COUNT_WIDTH'(1);
      // A new illegal transition wins over a same-cycle error_clear.
      error <= (error & ~error_clear) | illegal;
    end
  end

  // Velocity: modular difference recovers the true delta across a wrap;
  // the snapshot moves only on window ticks, so clear/index jumps show up.
  logic [COUNT_WIDTH-1:0]        snap;
  logic signed [COUNT_WIDTH-1:0] diff;
  logic signed [EW-1:0]          dext;

  assign diff = count - snap;
  assign dext = EW'(diff);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      snap     <= '0;
      velocity <= '0;
    end else if (tick) begin
      snap <= count;
      if (dext > VMAX)
        velocity <= VEL_WIDTH'(VMAX);
      else if (dext < VMIN)
        velocity <= VEL_WIDTH'(VMIN);
      else
        velocity <= VEL_WIDTH'(dext);
    end
  end
endmodule

module quad_encoder_array #(
  parameter int CHANNELS      = 2,
  parameter int COUNT_WIDTH   = 24,
  parameter int FILTER_CYCLES = 100,
  parameter int VEL_WINDOW    = 32000,
  parameter int VEL_WIDTH     = 16
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             quadA,
  input  logic [CHANNELS-1:0]             quadB,
  input  logic [CHANNELS-1:0]             index,
  input  logic [CHANNELS-1:0]             zero_on_index,
  input  logic [CHANNELS-1:0]             clear,
  input  logic                            error_clear,
  output logic [CHANNELS*COUNT_WIDTH-1:0] count,
  output logic [CHANNELS*VEL_WIDTH-1:0]   velocity,
  output logic                            velocity_valid,
  output logic [CHANNELS-1:0]             error
);
  localparam int WW = $clog2(VEL_WINDOW);

  logic [WW-1:0] win_cnt;
  logic          tick;

  assign tick = (win_cnt == WW'(VEL_WINDOW - 1));

  // Free-running window; velocity_valid is registered alongside the lanes'
  // velocity registers so both change on the same edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      win_cnt        <= '0;
      velocity_valid <= 1'b0;
    end else begin
      velocity_valid <= tick;
      win_cnt        <= tick ? '0 : win_cnt + WW'(1);
    end
  end

  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] count_arr;
  logic [CHANNELS-1:0][VEL_WIDTH-1:0]   vel_arr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    qe_lane #(
      .COUNT_WIDTH   (COUNT_WIDTH),
      .FILTER_CYCLES (FILTER_CYCLES),
      .VEL_WIDTH     (VEL_WIDTH)
    ) u_lane (
      .CLK           (CLK),
      .reset         (reset),
      .a             (quadA[i]),
      .b             (quadB[i]),
      .idx           (index[i]),
      .zero_on_index (zero_on_index[i]),
      .clear         (clear[i]),
      .error_clear   (error_clear),
      .tick          (tick),
      .count         (count_arr[i]),
      .velocity      (vel_arr[i]),
      .error         (error[i])
    );
  end

  assign count    = count_arr;
  assign velocity = vel_arr;
endmodule

// File: tb/tb_quad_encoder_array.sv
module tb_quad_encoder_array;
  localparam int CH = 2, CW = 8, FC = 4, VWIN = 100, VLW = 6;

  logic CLK = 1'b0, reset = 1'b1;
  logic [CH-1:0] quadA = '0, quadB = '0, index = '0, zero_on_index = '0, clear = '0;
  logic error_clear = 1'b0;
  logic [CH*CW-1:0]  count;
  logic [CH*VLW-1:0] velocity;
  logic              velocity_valid;
  logic [CH-1:0]     error;

  int total = 0, bad = 0;
  int ph [CH];

  always #5 CLK = ~CLK;

  quad_encoder_array #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .FILTER_CYCLES(FC),
    .VEL_WINDOW(VWIN), .VEL_WIDTH(VLW)
  ) dut (
    .CLK(CLK), .reset(reset), .quadA(quadA), .quadB(quadB), .index(index),
    .zero_on_index(zero_on_index), .clear(clear), .error_clear(error_clear),
    .count(count), .velocity(velocity), .velocity_valid(velocity_valid), .error(error)
  );

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int cnt(input int ch);
    logic signed [CW-1:0] v;
    v = count[ch*CW +: CW];
    return int'(v);
  endfunction

  function automatic int vel(input int ch);
    logic signed [VLW-1:0] v;
    v = velocity[ch*VLW +: VLW];
    return int'(v);
  endfunction

  // Phase 0..3 = {A,B} 00,10,11,01 (forward order).
  task automatic set_ph(input int ch, input int p);
    logic [1:0] ab;
    ph[ch] = p;
    case (p)
      0: ab = 2'b00;
      1: ab = 2'b10;
      2: ab = 2'b11;
      default: ab = 2'b01;
    endcase
    quadA[ch] = ab[1];
    quadB[ch] = ab[0];
  endtask

  task automatic step(input int ch, input int dir);
    set_ph(ch, (ph[ch] + dir + 4) % 4);
  endtask

  task automatic test_reset;
    cyc(3);
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%h exp=0", count); end
    total++; if (velocity !== '0) begin bad++; $display("FAIL rst_vel got=%h exp=0", velocity); end
    total++; if (velocity_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", velocity_valid); end
    total++; if (error !== '0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    reset = 1'b0;
  endtask

  task automatic test_fwd_rev;
    for (int s = 1; s <= 17; s++) begin
      int exp_old, exp_new;
      exp_old = (s <= 12) ? s - 1 : 25 - s;
      exp_new = (s <= 12) ? s : 24 - s;
      step(0, (s <= 12) ? 1 : -1);
      cyc(6);
      total++; if (cnt(0) !== exp_old) begin bad++; $display("FAIL lat_early step=%0d got=%0d exp=%0d", s, cnt(0), exp_old); end
      cyc(1);
      total++; if (cnt(0) !== exp_new) begin bad++; $display("FAIL lat_land step=%0d got=%0d exp=%0d", s, cnt(0), exp_new); end
      cyc(13);
    end
    total++; if (cnt(0) !== 7) begin bad++; $display("FAIL fwd_rev_ch0 got=%0d exp=7", cnt(0)); end
    total++; if (cnt(1) !== 0) begin bad++; $display("FAIL fwd_rev_ch1 got=%0d exp=0", cnt(1)); end
  endtask

  task automatic test_glitch_illegal;
    quadA[1] = 1'b1; cyc(3); quadA[1] = 1'b0; cyc(20);
    total++; if (cnt(1) !== 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", cnt(1)); end
    total++; if (error !== 2'b00) begin bad++; $display("FAIL glitch_error got=%b exp=00", error); end
    quadA[1] = 1'b1; quadB[1] = 1'b1; ph[1] = 2; cyc(10);
    total++; if (error !== 2'b10) begin bad++; $display("FAIL illegal_error got=%b exp=10", error); end
    total++; if (cnt(1) !== 0) begin bad++; $display("FAIL illegal_count got=%0d exp=0", cnt(1)); end
    error_clear = 1'b1; cyc(1); error_clear = 1'b0;
    total++; if (error !== 2'b00) begin bad++; $display("FAIL err_clear got=%b exp=00", error); end
    // Second illegal toggle lands on the same edge as error_clear.
    quadA[1] = 1'b0; quadB[1] = 1'b0; ph[1] = 0; cyc(6);
    error_clear = 1'b1; cyc(1); error_clear = 1'b0;
    total++; if (error !== 2'b10) begin bad++; $display("FAIL err_vs_clear got=%b exp=10", error); end
    total++; if (cnt(1) !== 0) begin bad++; $display("FAIL illegal2_count got=%0d exp=0", cnt(1)); end
    error_clear = 1'b1; cyc(1); error_clear = 1'b0;
    total++; if (error !== 2'b00) begin bad++; $display("FAIL err_clear2 got=%b exp=00", error); end
  endtask

  task automatic test_wrap;
    clear[0] = 1'b1; cyc(1); clear[0] = 1'b0;
    total++; if (cnt(0) !== 0) begin bad++; $display("FAIL wrap_clear got=%0d exp=0", cnt(0)); end
    for (int i = 0; i < 127; i++) begin step(0, 1); cyc(8); end
    total++; if (cnt(0) !== 127) begin bad++; $display("FAIL wrap_preload got=%0d exp=127", cnt(0)); end
    step(0, 1); cyc(8);
    total++; if (cnt(0) !== -128) begin bad++; $display("FAIL wrap_up got=%0d exp=-128", cnt(0)); end
    step(0, -1); cyc(8);
    total++; if (cnt(0) !== 127) begin bad++; $display("FAIL wrap_down got=%0d exp=127", cnt(0)); end
  endtask

  task automatic test_index_clear;
    clear[0] = 1'b1; cyc(1); clear[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin step(0, 1); cyc(8); end
    total++; if (cnt(0) !== 9) begin bad++; $display("FAIL idx_pre got=%0d exp=9", cnt(0)); end
    zero_on_index[0] = 1'b1; index[0] = 1'b1; step(0, 1); cyc(10);
    total++; if (cnt(0) !== 0) begin bad++; $display("FAIL idx_zero got=%0d exp=0", cnt(0)); end
    index[0] = 1'b0; cyc(8); zero_on_index[0] = 1'b0;
    total++; if (cnt(0) !== 0) begin bad++; $display("FAIL idx_fall got=%0d exp=0", cnt(0)); end
    step(0, 1); cyc(8);
    for (int i = 0; i < 3; i++) begin step(1, -1); cyc(8); end
    total++; if (cnt(1) !== -3) begin bad++; $display("FAIL clr_pre got=%0d exp=-3", cnt(1)); end
    total++; if (cnt(0) !== 1) begin bad++; $display("FAIL clr_pre_ch0 got=%0d exp=1", cnt(0)); end
    clear[1] = 1'b1; cyc(1); clear[1] = 1'b0;
    total++; if (cnt(1) !== 0) begin bad++; $display("FAIL clr_ch1 got=%0d exp=0", cnt(1)); end
    total++; if (cnt(0) !== 1) begin bad++; $display("FAIL clr_ch0_kept got=%0d exp=1", cnt(0)); end
  endtask

  task automatic test_velocity;
    // Realign: pins to 00 under reset so release produces no transitions.
    reset = 1'b1; set_ph(0, 0); set_ph(1, 0); cyc(2); reset = 1'b0;
    // Two windows of 10 steps, 10 cycles apart.
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 10; j++) begin
        step(0, 1);
        if (j == 0) begin
          cyc(1);
          if (w == 1) begin
            total++; if (velocity_valid !== 1'b0) begin bad++; $display("FAIL vv_width got=%b exp=0", velocity_valid); end
          end
          cyc(9);
        end else if (j == 9) begin
          cyc(9);
          total++; if (velocity_valid !== 1'b0) begin bad++; $display("FAIL vv_early w=%0d got=%b exp=0", w, velocity_valid); end
          cyc(1);
        end else begin
          cyc(10);
        end
      end
      total++; if (velocity_valid !== 1'b1) begin bad++; $display("FAIL vv_tick w=%0d got=%b exp=1", w, velocity_valid); end
      total++; if (vel(0) !== 10) begin bad++; $display("FAIL vel10 w=%0d got=%0d exp=10", w, vel(0)); end
      total++; if (vel(1) !== 0) begin bad++; $display("FAIL vel_ch1 w=%0d got=%0d exp=0", w, vel(1)); end
    end
    // Count 20, snapshot 20. Clear then 40 reverse steps: window delta -43 -> -32.
    clear[0] = 1'b1; cyc(1); clear[0] = 1'b0; cyc(3);
    for (int k = 0; k < 40; k++) begin
      step(0, -1); cyc(4);
      if (k == 23) begin
        total++; if (velocity_valid !== 1'b1) begin bad++; $display("FAIL vv_sat_neg got=%b exp=1", velocity_valid); end
        total++; if (vel(0) !== -32) begin bad++; $display("FAIL vel_sat_neg got=%0d exp=-32", vel(0)); end
      end
    end
    cyc(36);
    total++; if (vel(0) !== -17) begin bad++; $display("FAIL vel_m17 got=%0d exp=-17", vel(0)); end
    total++; if (cnt(0) !== -40) begin bad++; $display("FAIL cnt_m40 got=%0d exp=-40", cnt(0)); end
    // Mid-window clear: snapshot stays -40, so next delta is +40 -> 31.
    cyc(20); clear[0] = 1'b1; cyc(1); clear[0] = 1'b0; cyc(79);
    total++; if (velocity_valid !== 1'b1) begin bad++; $display("FAIL vv_sat_pos got=%b exp=1", velocity_valid); end
    total++; if (vel(0) !== 31) begin bad++; $display("FAIL vel_sat_pos got=%0d exp=31", vel(0)); end
    for (int j = 0; j < 3; j++) begin step(0, 1); cyc(10); end
    cyc(10);
    total++; if (cnt(0) !== 3) begin bad++; $display("FAIL pre_async got=%0d exp=3", cnt(0)); end
    // Async reset between clock edges.
    #2; reset = 1'b1; set_ph(0, 0); set_ph(1, 0);
    #1;
    total++; if (count !== '0) begin bad++; $display("FAIL async_count got=%h exp=0", count); end
    total++; if (velocity !== '0) begin bad++; $display("FAIL async_vel got=%h exp=0", velocity); end
    total++; if (velocity_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", velocity_valid); end
    total++; if (error !== '0) begin bad++; $display("FAIL async_error got=%b exp=0", error); end
    cyc(1); reset = 1'b0;
    cyc(99);
    total++; if (velocity_valid !== 1'b0) begin bad++; $display("FAIL post_rst_early got=%b exp=0", velocity_valid); end
    cyc(1);
    total++; if (velocity_valid !== 1'b1) begin bad++; $display("FAIL post_rst_tick got=%b exp=1", velocity_valid); end
    total++; if (vel(0) !== 0) begin bad++; $display("FAIL post_rst_vel got=%0d exp=0", vel(0)); end
  endtask

  initial begin
    ph[0] = 0;
    ph[1] = 0;
    test_reset;
    test_fwd_rev;
    test_glitch_illegal;
    test_wrap;
    test_index_clear;
    test_velocity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
